// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sequencer that shares one combinational 8-bit ALU
// between two valid/ready requesters, returning an ID-tagged registered result.
// Ports: clk, rst (sync, active-high); req0_*/req1_* command channels
// (valid/ready, a, b, op); rsp_* response channel (valid/ready, id, out,
// overflow, carry); alu_* operands/operator out and result/flags in;
// done_count counts consumed responses modulo 2^CNT_W.
// Optional feature: define ALU_ARBITER_DIV0_TRAP_EN to trap divide/modulo by
// zero (op 4'b0011 / 4'b0100 with b == 0) as out=16'hFFFF, overflow=1, carry=0.
module alu_arbiter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [7:0]       req0_a,
   input  logic [7:0]       req0_b,
   input  logic [3:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [7:0]       req1_a,
   input  logic [7:0]       req1_b,
   input  logic [3:0]       req1_op,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [15:0]      rsp_out,
   output logic             rsp_overflow,
   output logic             rsp_carry,
   output logic [7:0]       alu_a,
   output logic [7:0]       alu_b,
   output logic [3:0]       alu_operator,
   input  logic [15:0]      alu_out,
   input  logic             alu_overflow,
   input  logic             alu_carry,
   output logic [CNT_W-1:0] done_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      RESP
   } state_t;

   state_t           state_q, state_d;
   logic             last_id_q, last_id_d;
   logic [7:0]       a_q, a_d;
   logic [7:0]       b_q, b_d;
   logic [3:0]       op_q, op_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [15:0]      rsp_out_q, rsp_out_d;
   logic             rsp_ov_q, rsp_ov_d;
   logic             rsp_cy_q, rsp_cy_d;
   logic [CNT_W-1:0] done_q, done_d;

   logic gnt0;
   logic gnt1;
   logic trap;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      gnt0 = req0_valid & (~req1_valid | last_id_q);
      gnt1 = req1_valid & (~req0_valid | ~last_id_q);
   end

   assign req0_ready = (state_q == IDLE) & gnt0;
   assign req1_ready = (state_q == IDLE) & gnt1;

`ifdef ALU_ARBITER_DIV0_TRAP_EN
   assign trap = ((op_q == 4'b0011) | (op_q == 4'b0100)) & (b_q == 8'd0);
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      last_id_d   = last_id_q;
      a_d         = a_q;
      b_d         = b_q;
      op_d        = op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_out_d   = rsp_out_q;
      rsp_ov_d    = rsp_ov_q;
      rsp_cy_d    = rsp_cy_q;
      done_d      = done_q;
      unique case (state_q)
         IDLE: begin
            if (req0_ready | req1_ready) begin
               state_d   = EXEC;
               last_id_d = req1_ready;
               rsp_id_d  = req1_ready;
               a_d       = req1_ready ? req1_a  : req0_a;
               b_d       = req1_ready ? req1_b  : req0_b;
               op_d      = req1_ready ? req1_op : req0_op;
            end
         end
         EXEC: begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            if (trap) begin
               rsp_out_d = 16'hFFFF;
               rsp_ov_d  = 1'b1;
               rsp_cy_d  = 1'b0;
            end else begin
               rsp_out_d = alu_out;
               rsp_ov_d  = alu_overflow;
               rsp_cy_d  = alu_carry;
            end
         end
         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
               done_d      = done_q + 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_id_q   <= 1'b1;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_out_q   <= '0;
         rsp_ov_q    <= 1'b0;
         rsp_cy_q    <= 1'b0;
         done_q      <= '0;
      end else begin
         state_q     <= state_d;
         last_id_q   <= last_id_d;
         a_q         <= a_d;
         b_q         <= b_d;
         op_q        <= op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_out_q   <= rsp_out_d;
         rsp_ov_q    <= rsp_ov_d;
         rsp_cy_q    <= rsp_cy_d;
         done_q      <= done_d;
      end
   end

   assign alu_a        = a_q;
   assign alu_b        = b_q;
   assign alu_operator = op_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_id       = rsp_id_q;
   assign rsp_out      = rsp_out_q;
   assign rsp_overflow = rsp_ov_q;
   assign rsp_carry    = rsp_cy_q;
   assign done_count   = done_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter against a
// transaction-level model, with a behavioural ALU attached to the alu_* ports.
module tb_alu_arbiter;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req1_valid;
   logic             req0_ready, req1_ready;
   logic [7:0]       req0_a, req0_b, req1_a, req1_b;
   logic [3:0]       req0_op, req1_op;
   logic             rsp_valid, rsp_ready, rsp_id;
   logic [15:0]      rsp_out;
   logic             rsp_overflow, rsp_carry;
   logic [7:0]       alu_a, alu_b;
   logic [3:0]       alu_operator;
   logic [15:0]      alu_out;
   logic             alu_overflow, alu_carry;
   logic [CNT_W-1:0] done_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_out(rsp_out), .rsp_overflow(rsp_overflow),
      .rsp_carry(rsp_carry),
      .alu_a(alu_a), .alu_b(alu_b), .alu_operator(alu_operator),
      .alu_out(alu_out), .alu_overflow(alu_overflow),
      .alu_carry(alu_carry),
      .done_count(done_count)
   );

   // Behavioural ALU: returns {overflow, carry, out}.
   function automatic logic [17:0] alu_f(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [3:0] op);
      logic [8:0]  s;
      logic [15:0] o;
      logic        ov, cy;
      o = '0; ov = 1'b0; cy = 1'b0;
      case (op)
         4'd0: begin
            s = {1'b0, a} + {1'b0, b};
            o = {7'd0, s}; cy = s[8];
            ov = (a[7] == b[7]) && (s[7] != a[7]);
         end
         4'd1: begin
            s = {1'b0, a} - {1'b0, b};
            o = {8'd0, s[7:0]}; cy = s[8];
            ov = (a[7] != b[7]) && (s[7] != a[7]);
         end
         4'd2: o = a * b;
         4'd3: if (b == 0) begin o = 16'h00FF; ov = 1; cy = 1; end
               else o = {8'd0, a / b};
         4'd4: if (b == 0) begin o = {8'd0, a}; ov = 1; cy = 1; end
               else o = {8'd0, a % b};
         4'd5: o = {8'd0, a & b};
         4'd6: o = {8'd0, a | b};
         4'd7: o = {8'd0, a ^ b};
         4'd14: o = {a, b};
         4'd15: o = 16'd0;
         default: o = {op, 4'h0, a ^ b};
      endcase
      return {ov, cy, o};
   endfunction

   // Expected response for an accepted operation.
   function automatic logic [17:0] model_rsp(input logic [7:0] a,
                                             input logic [7:0] b,
                                             input logic [3:0] op);
      logic [17:0] r;
      r = alu_f(a, b, op);
`ifdef ALU_ARBITER_DIV0_TRAP_EN
      if ((op == 4'd3 || op == 4'd4) && b == 8'd0) r = {2'b10, 16'hFFFF};
`endif
      return r;
   endfunction

   always_comb begin
      {alu_overflow, alu_carry, alu_out} = alu_f(alu_a, alu_b, alu_operator);
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Leaves the bench at the negedge where rsp_valid is high.
   task automatic wait_rsp(input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) begin ok = 1; break; end
      end
      if (!ok) chk({tag, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic check_rsp(input string tag, input logic id,
                            input logic [17:0] r);
      chk({tag, "_id"}, rsp_id, id);
      chk({tag, "_out"}, rsp_out, r[15:0]);
      chk({tag, "_ov"}, rsp_overflow, r[17]);
      chk({tag, "_cy"}, rsp_carry, r[16]);
   endtask

   task automatic issue(input logic id, input logic [7:0] a,
                        input logic [7:0] b, input logic [3:0] op);
      bit ok;
      if (id) begin
         req1_valid = 1; req1_a = a; req1_b = b; req1_op = op;
      end else begin
         req0_valid = 1; req0_a = a; req0_b = b; req0_op = op;
      end
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((id ? req1_ready : req0_ready) === 1'b1) begin ok = 1; break; end
      end
      if (!ok) chk("issue_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      if (id) req1_valid = 0; else req0_valid = 0;
   endtask

   // Transaction-level model state for the random phase.
   int               m_phase;
   logic             m_last;
   logic [CNT_W-1:0] m_done;
   logic [18:0]      m_exp;
   logic [19:0]      m_opnd;

   initial begin
      logic [CNT_W-1:0] d0;
      logic e0, e1, acc0, acc1, cons;

      rst = 1; rsp_ready = 1;
      req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
      req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
      do_reset();

      // Reset state
      @(negedge clk);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_out", rsp_out, 0);
      chk("rst_rsp_flags", {rsp_overflow, rsp_carry}, 0);
      chk("rst_alu", {alu_a, alu_b, alu_operator}, 0);
      chk("rst_done", done_count, 0);
      chk("rst_ready", {req0_ready, req1_ready}, 0);

      // Single op with exact cycle timing
      req0_valid = 1; req0_a = 8'd100; req0_b = 8'd27; req0_op = 4'd0;
      #1 chk("single_ready", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk);
      #1 req0_valid = 0;
      @(negedge clk);
      chk("single_exec_valid", rsp_valid, 0);
      chk("single_alu_ab", {alu_a, alu_b}, {8'd100, 8'd27});
      @(negedge clk);
      chk("single_valid", rsp_valid, 1);
      check_rsp("single", 0, {2'b00, 16'd127});
      @(negedge clk);
      chk("single_consumed", rsp_valid, 0);
      chk("single_done", done_count, 1);

      // Simultaneous requests from reset
      req0_valid = 1; req0_a = 8'hF0; req0_b = 8'h3C; req0_op = 4'b0101;
      req1_valid = 1; req1_a = 8'h12; req1_b = 8'h34; req1_op = 4'b1110;
      do_reset();
      wait_rsp("tie1");
      check_rsp("tie1", 0, {2'b00, 16'h0030});
      @(posedge clk); #1;
      wait_rsp("tie2");
      check_rsp("tie2", 1, {2'b00, 16'h1234});
      @(posedge clk); #1;
      @(negedge clk);
      chk("tie3_grant", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk);
      #1 req0_valid = 0; req1_valid = 0;
      wait_rsp("tie3");
      check_rsp("tie3", 0, {2'b00, 16'h0030});
      @(posedge clk); #1;

      // Back-pressure with a pending requester
      rsp_ready = 0;
      issue(1, 8'hAA, 8'h0F, 4'd7);
      req0_valid = 1; req0_a = 8'd1; req0_b = 8'd2; req0_op = 4'd0;
      wait_rsp("bp");
      d0 = done_count;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk("bp_hold_valid", rsp_valid, 1);
         check_rsp("bp_hold", 1, {2'b00, 16'h00A5});
         chk("bp_ready_low", {req0_ready, req1_ready}, 0);
         chk("bp_done_hold", done_count, d0);
      end
      rsp_ready = 1;
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_released", rsp_valid, 0);
      chk("bp_done_inc", done_count, d0 + 1'b1);
      chk("bp_pending_grant", {req0_ready, req1_ready}, 2'b10);
      @(posedge clk);
      #1 req0_valid = 0;
      wait_rsp("bp_next");
      check_rsp("bp_next", 0, {2'b00, 16'd3});
      @(posedge clk); #1;

      // Signed overflow
      issue(0, 8'h7F, 8'h01, 4'd0);
      wait_rsp("ovf");
      chk("ovf_low", rsp_out[7:0], 8'h80);
      chk("ovf_flag", rsp_overflow, 1);
      chk("ovf_carry", rsp_carry, 0);
      @(posedge clk); #1;

      // Divide by zero
      issue(1, 8'd9, 8'd0, 4'd3);
      wait_rsp("div0");
`ifdef ALU_ARBITER_DIV0_TRAP_EN
      check_rsp("div0", 1, {2'b10, 16'hFFFF});
`else
      check_rsp("div0", 1, {2'b11, 16'h00FF});
`endif
      @(posedge clk); #1;

      // Reset while in RESP
      rsp_ready = 0;
      issue(0, 8'd5, 8'd6, 4'd6);
      wait_rsp("rresp");
      req0_valid = 1; req0_a = 8'd3; req0_b = 8'd4; req0_op = 4'd0;
      req1_valid = 1; req1_a = 8'd7; req1_b = 8'd8; req1_op = 4'd0;
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      chk("rresp_valid", rsp_valid, 0);
      chk("rresp_done", done_count, 0);
      chk("rresp_grant", {req0_ready, req1_ready}, 2'b10);
      rsp_ready = 1;
      @(posedge clk);
      #1 req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      chk("rresp_accept", {alu_a, alu_b}, {8'd3, 8'd4});
      wait_rsp("rresp_next");
      check_rsp("rresp_next", 0, {2'b00, 16'd7});
      @(posedge clk); #1;

      // Randomized traffic against the transaction model
      do_reset();
      m_phase = 0; m_last = 1; m_done = '0; m_exp = '0; m_opnd = '0;
      for (int c = 0; c < 800; c++) begin
         @(negedge clk);
         e0 = (m_phase == 0) && req0_valid && (!req1_valid || m_last);
         e1 = (m_phase == 0) && req1_valid && (!req0_valid || !m_last);
         chk("rnd_ready", {req0_ready, req1_ready}, {e0, e1});
         chk("rnd_valid", rsp_valid, m_phase == 2);
         chk("rnd_done", done_count, m_done);
         if (m_phase == 1)
            chk("rnd_alu_in", {alu_a, alu_b, alu_operator}, m_opnd);
         if (m_phase == 2)
            check_rsp("rnd_rsp", m_exp[18], m_exp[17:0]);
         acc0 = e0; acc1 = e1;
         cons = (m_phase == 2) && rsp_ready;
         @(posedge clk);
         #1;
         if (acc0) begin
            m_phase = 1; m_last = 0;
            m_opnd = {req0_a, req0_b, req0_op};
            m_exp = {1'b0, model_rsp(req0_a, req0_b, req0_op)};
         end else if (acc1) begin
            m_phase = 1; m_last = 1;
            m_opnd = {req1_a, req1_b, req1_op};
            m_exp = {1'b1, model_rsp(req1_a, req1_b, req1_op)};
         end else if (m_phase == 1) begin
            m_phase = 2;
         end else if (cons) begin
            m_phase = 0;
            m_done = m_done + 1'b1;
         end
         if (acc0 || !req0_valid) begin
            req0_valid = ($urandom_range(0, 2) != 0);
            req0_a = 8'($urandom);
            req0_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            req0_op = 4'($urandom_range(0, 15));
         end
         if (acc1 || !req1_valid) begin
            req1_valid = ($urandom_range(0, 2) != 0);
            req1_a = 8'($urandom);
            req1_b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            req1_op = 4'($urandom_range(0, 15));
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
